// File: rtl/toeplitz_row_gen.sv
// toeplitz_row_gen
//   Feeds the Toeplitz row-accumulate stage. It reads the seed image from a
//   registered seed memory and builds the first ROW_W-bit row. After that it
//   presents one row per accepted handshake. Each new row is the previous row
//   shifted left by one, with the next seed tail bit placed in bit 0.
//
// Ports
//   clk_in        rising-edge clock
//   rst           asynchronous active-low reset
//   start         one-cycle pulse; begins a run when idle
//   seed_adress   seed memory address
//   seed_read_en  seed memory read enable
//   seed_data     seed memory data, valid one cycle after address/enable
//   shift_row     current Toeplitz row
//   sum_en        shift_row valid
//   row_ready     downstream accepts the row when sum_en && row_ready
//   row_idx       index of the row on shift_row
//   busy          high from start acceptance until done
//   done          one-cycle pulse after the last row is accepted
module toeplitz_row_gen #(
  parameter int ROW_W    = 3072,
  parameter int WORD_W   = 32,
  parameter int NUM_ROWS = 1024,
  parameter int ADDR_W   = 7,
  parameter int IDX_W    = 10
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] seed_adress,
  output logic              seed_read_en,
  input  logic [WORD_W-1:0] seed_data,
  output logic [ROW_W-1:0]  shift_row,
  output logic              sum_en,
  input  logic              row_ready,
  output logic [IDX_W-1:0]  row_idx,
  output logic              busy,
  output logic              done
);

  localparam int W          = ROW_W / WORD_W;
  localparam int TAIL_WORDS = (NUM_ROWS - 1 + WORD_W - 1) / WORD_W;
  // Highest address of the seed image; refills never go past it.
  localparam int LAST_ADDR  = W + TAIL_WORDS - 1;
  localparam int PTR_W      = $clog2(WORD_W);
  localparam int CAP_W      = $clog2(W + 2);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(WORD_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q,     state_d;
  logic [ROW_W-1:0]  row_q,       row_d;
  logic [IDX_W-1:0]  idx_q,       idx_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic              rd_en_q,     rd_en_d;
  logic              rd_pend_q,   rd_pend_d;   // a read issued last cycle returns data now
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              sum_en_q,    sum_en_d;
  logic [WORD_W-1:0] tail_cur_q,  tail_cur_d;
  logic [WORD_W-1:0] tail_nxt_q,  tail_nxt_d;
  logic [PTR_W-1:0]  ptr_q,       ptr_d;
  logic [CAP_W-1:0]  cap_q,       cap_d;       // words captured during LOAD
  logic              accept;

  assign accept = sum_en_q && row_ready;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    rd_en_d    = 1'b0;
    rd_pend_d  = rd_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sum_en_d   = sum_en_q;
    tail_cur_d = tail_cur_q;
    tail_nxt_d = tail_nxt_q;
    ptr_d      = ptr_q;
    cap_d      = cap_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
          addr_d  = '0;
          rd_en_d = 1'b1;
          cap_d   = '0;
          idx_d   = '0;
          ptr_d   = '0;
        end
      end

      S_LOAD: begin
        // Address issue runs two cycles ahead of data capture.
        if (rd_en_q && addr_q != ADDR_W'(W + 1)) begin
          addr_d  = addr_q + ADDR_W'(1);
          rd_en_d = 1'b1;
        end
        if (rd_pend_q) begin
          cap_d = cap_q + CAP_W'(1);
          if (cap_q < CAP_W'(W)) begin
            row_d = {row_q[ROW_W-WORD_W-1:0], seed_data};
          end else if (cap_q == CAP_W'(W)) begin
            tail_cur_d = seed_data;
          end else begin
            tail_nxt_d = seed_data;
            state_d    = S_RUN;
            sum_en_d   = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (rd_pend_q) begin
          tail_nxt_d = seed_data;
        end
        if (accept) begin
          if (idx_q == IDX_W'(NUM_ROWS - 1)) begin
            sum_en_d = 1'b0;
            state_d  = S_DONE;
            done_d   = 1'b1;
            busy_d   = 1'b0;
          end else begin
            // Tail bits are consumed MSB-first.
            row_d = {row_q[ROW_W-2:0], tail_cur_q[PTR_MAX - ptr_q]};
            idx_d = idx_q + IDX_W'(1);
            ptr_d = ptr_q + PTR_W'(1);
            if (ptr_q == PTR_MAX) begin
              // The refill lands two cycles from now, long before the
              // 32 accepts that drain tail_cur.
              tail_cur_d = tail_nxt_q;
              ptr_d      = '0;
              if (int'(addr_q) < LAST_ADDR) begin
                addr_d  = addr_q + ADDR_W'(1);
                rd_en_d = 1'b1;
              end
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sum_en_q   <= 1'b0;
      tail_cur_q <= '0;
      tail_nxt_q <= '0;
      ptr_q      <= '0;
      cap_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      rd_pend_q  <= rd_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sum_en_q   <= sum_en_d;
      tail_cur_q <= tail_cur_d;
      tail_nxt_q <= tail_nxt_d;
      ptr_q      <= ptr_d;
      cap_q      <= cap_d;
    end
  end

  assign seed_adress  = addr_q;
  assign seed_read_en = rd_en_q;
  assign shift_row    = row_q;
  assign sum_en       = sum_en_q;
  assign row_idx      = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_toeplitz_row_gen.sv
// Bench for toeplitz_row_gen. The reference row r is the seed bit stream
// (each word MSB-first, words in address order) read from bit r onward.
module tb_toeplitz_row_gen;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [6:0]    seed_adress;
  logic          seed_read_en;
  logic [31:0]   seed_data;
  logic [3071:0] shift_row;
  logic          sum_en;
  logic          row_ready;
  logic [9:0]    row_idx;
  logic          busy;
  logic          done;

  logic          start1;
  logic [6:0]    adr1;
  logic          rd1_en;
  logic [31:0]   data1;
  logic [3071:0] row1;
  logic          sum_en1;
  logic          ready1;
  logic [9:0]    idx1;
  logic          busy1;
  logic          done1;

  logic [31:0] mem [0:127];

  int checks = 0;
  int errors = 0;
  int exp_addr = 0;
  int rd_count = 0;
  int rd1_count = 0;

  typedef struct {
    int          row;
    logic [31:0] hi;
    logic [31:0] lo;
  } spot_t;
  spot_t spots [6];

  always #5 clk = ~clk;

  toeplitz_row_gen u_dut (
    .clk_in(clk), .rst(rst), .start(start),
    .seed_adress(seed_adress), .seed_read_en(seed_read_en), .seed_data(seed_data),
    .shift_row(shift_row), .sum_en(sum_en), .row_ready(row_ready),
    .row_idx(row_idx), .busy(busy), .done(done)
  );

  toeplitz_row_gen #(.NUM_ROWS(1)) u_one (
    .clk_in(clk), .rst(rst), .start(start1),
    .seed_adress(adr1), .seed_read_en(rd1_en), .seed_data(data1),
    .shift_row(row1), .sum_en(sum_en1), .row_ready(ready1),
    .row_idx(idx1), .busy(busy1), .done(done1)
  );

  // Registered seed memories.
  always @(posedge clk) begin
    if (seed_read_en) seed_data <= mem[seed_adress];
    if (rd1_en) data1 <= mem[adr1];
  end

  function automatic logic [3071:0] golden(input int r);
    logic [3071:0] v;
    for (int i = 0; i < 3072; i++) begin
      int j;
      j = r + i;
      v[3071-i] = mem[j/32][31-(j%32)];
    end
    return v;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_row(input string nm, input int r, input logic [3071:0] act,
                         input logic [3071:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got hi %h lo %h want hi %h lo %h", nm, r,
               act[3071:3040], act[31:0], exp[3071:3040], exp[31:0]);
    end
  endtask

  // Seed reads must walk the image in address order.
  always @(negedge clk) begin
    if (rst && seed_read_en) begin
      chk32("read_addr", 32'(seed_adress), 32'(exp_addr));
      exp_addr++;
      rd_count++;
    end
    if (rst && rd1_en) rd1_count++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    int lat;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk32("busy_after_start", 32'(busy), 32'd1);
    for (lat = 1; lat <= 300; lat++) begin
      @(posedge clk);
      #1;
      if (sum_en) break;
    end
    chk32("first_row_latency", 32'(lat), 32'd99);
  endtask

  task automatic run(input bit rnd, input int restart_at, input int abort_at, input bit spot);
    int n, dones;
    bit stalled, rdy, aborted;
    logic [3071:0] prev_row;
    logic [9:0] prev_idx;
    n = 0; dones = 0; stalled = 0; aborted = 0;
    prev_row = '0; prev_idx = '0;
    exp_addr = 0; rd_count = 0;
    pulse_start();
    for (int cyc = 0; cyc < 20000 && dones == 0 && !aborted; cyc++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        chk32("busy_low_on_done", 32'(busy), 32'd0);
        continue;
      end
      if (stalled) begin
        chk_row("stall_row", n, shift_row, prev_row);
        chk32("stall_idx", 32'(row_idx), 32'(prev_idx));
      end
      stalled = 0;
      if (abort_at >= 0 && n == abort_at) begin
        rst = 1'b0;
        row_ready = 1'b0;
        #1;
        chk32("abort_sum_en", 32'(sum_en), 32'd0);
        chk32("abort_busy", 32'(busy), 32'd0);
        chk32("abort_idx", 32'(row_idx), 32'd0);
        chk_row("abort_row", n, shift_row, '0);
        aborted = 1;
      end else begin
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        row_ready = rdy;
        start = (n == restart_at);
        if (sum_en) begin
          chk32("busy_in_run", 32'(busy), 32'd1);
          if (rdy) begin
            chk32("row_idx", 32'(row_idx), 32'(n));
            chk_row("row", n, shift_row, golden(n));
            if (spot) begin
              for (int s = 0; s < 6; s++) begin
                if (spots[s].row == n) begin
                  chk32("spot_hi", shift_row[3071:3040], spots[s].hi);
                  chk32("spot_lo", shift_row[31:0], spots[s].lo);
                end
              end
            end
            n++;
          end else begin
            stalled = 1;
            prev_row = shift_row;
            prev_idx = row_idx;
          end
        end
      end
    end
    start = 1'b0;
    row_ready = 1'b0;
    if (aborted) begin
      @(negedge clk);
      rst = 1'b1;
      return;
    end
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk32("accepts", 32'(n), 32'd1024);
    chk32("done_count", 32'(dones), 32'd1);
    chk32("read_count", 32'(rd_count), 32'd128);
    chk32("idle_sum_en", 32'(sum_en), 32'd0);
    chk32("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    spots[0] = '{row: 0,    hi: 32'h00000000, lo: 32'h0000005F};
    spots[1] = '{row: 1,    hi: 32'h00000000, lo: 32'h000000BE};
    spots[2] = '{row: 32,   hi: 32'h00000001, lo: 32'h00000060};
    spots[3] = '{row: 33,   hi: 32'h00000002, lo: 32'h000000C0};
    spots[4] = '{row: 64,   hi: 32'h00000002, lo: 32'h00000061};
    spots[5] = '{row: 1023, hi: 32'h80000010, lo: 32'h0000003F};

    for (int k = 0; k < 128; k++) mem[k] = 32'(k);
    rst = 1'b0; start = 1'b0; row_ready = 1'b0; start1 = 1'b0; ready1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk32("rst_sum_en", 32'(sum_en), 32'd0);
    chk32("rst_busy", 32'(busy), 32'd0);
    chk32("rst_done", 32'(done), 32'd0);
    chk32("rst_read_en", 32'(seed_read_en), 32'd0);
    chk32("rst_addr", 32'(seed_adress), 32'd0);
    chk32("rst_idx", 32'(row_idx), 32'd0);
    chk_row("rst_row", 0, shift_row, '0);
    @(negedge clk);
    rst = 1'b1;

    run(1'b0, -1, -1, 1'b1);   // full run, always ready
    run(1'b1, -1, -1, 1'b1);   // random backpressure
    run(1'b0, 500, -1, 1'b1);  // start re-pulsed mid-run
    run(1'b0, -1, 300, 1'b0);  // reset mid-run
    run(1'b0, -1, -1, 1'b1);   // restart after abort

    for (int k = 0; k < 128; k++) mem[k] = $urandom;
    run(1'b1, -1, -1, 1'b0);   // random seed, random backpressure

    // Single-row instance.
    rd1_count = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (lat = 1; lat <= 300; lat++) begin
      @(posedge clk);
      #1;
      if (sum_en1) break;
    end
    chk32("one_latency", 32'(lat), 32'd99);
    @(negedge clk);
    chk_row("one_row", 0, row1, golden(0));
    chk32("one_idx", 32'(idx1), 32'd0);
    ready1 = 1'b1;
    @(negedge clk);
    ready1 = 1'b0;
    chk32("one_done", 32'(done1), 32'd1);
    chk32("one_sum_en", 32'(sum_en1), 32'd0);
    chk32("one_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    chk32("one_done_once", 32'(done1), 32'd0);
    repeat (3) @(negedge clk);
    chk32("one_reads", 32'(rd1_count), 32'd98);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
